alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Execute and writeback stage directly downstream of the ALU instruction decoder.
- Consumes the decoded operand selects, destination address, opcode and active-low strobe.
- Owns the four architectural data registers A, X, Y, D and the flag register; reads operands, computes (multi-cycle for MUL), writes back.
- Holds off the decoder with in_ready while busy.

Parameters:
- WIDTH, 8, data register / ALU width
- MUL_EN, 1, 1 = iterative multiply implemented; 0 = opcode 0xE treated as illegal

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ce_n  in  1  instruction strobe, active-low; low = decoded instruction valid
- opcode  in  4  ALU operation
- src_a  in  4  operand A select: 0=A 1=X 2=Y 3=D, 4..15 illegal
- src_b  in  4  operand B select, same encoding
- load_addr  in  8  destination: [7:4] must be 4'h1 to write; [1:0] selects A/X/Y/D as above
- in_ready  out  1  stage can accept an instruction this cycle
- busy  out  1  instruction in flight
- done  out  1  one-cycle pulse on the writeback edge
- result  out  WIDTH  last computed result (low half for MUL)
- flags  out  4  {N,V,C,Z}, last computed
- err  out  1  sticky illegal-select/opcode flag, cleared only by rst
- ld_en  in  1  external register load strobe
- ld_sel  in  2  external load target A/X/Y/D
- ld_data  in  WIDTH  external load value
- dbg_sel  in  2  debug read select
- dbg_data  out  WIDTH  combinational read of selected register

Behaviour:
- Reset (async, rst=1): A=X=Y=D=0, result=0, flags=0, err=0, done=0, busy=0, in_ready=1, FSM to IDLE, multiply counter 0. An in-flight instruction is abandoned; no writeback occurs.
- Reset release: first accept is possible on the first rising edge with rst=0.
- FSM states: IDLE, EXEC, MULT.
- Accept condition: IDLE and ce_n=0 (in_ready=1 only in IDLE). On the accept edge: latch opA/opB register values, opcode, destination, write-enable (load_addr[7:4]==4'h1); go to EXEC.
- ce_n while in_ready=0: ignored; the decoder must hold its outputs.
- Illegal select (src >3): that operand reads 0 and err sets.
- EXEC, opcode != 0xE: compute; on the next edge write dest (if enabled), result, flags; pulse done; return to IDLE. Latency 2 edges from accept; throughput 1 instruction per 2 cycles.
- Opcodes:
  - 0 ADD, 1 ADC (+C), 2 SUB (A-B), 3 SBB (A-B-C)
  - 4 AND, 5 OR, 6 XOR, 7 NOT A
  - 8 SHL, 9 SHR (logical, C = shifted-out bit), A ROL through C, B ROR through C
  - C INC A, D DEC A, E MUL, F PASS B
- Arithmetic: WIDTH+1-bit internal sum.
  - C = carry-out (ADD/ADC/INC); C = borrow (SUB/SBB/DEC).
  - V = two's-complement overflow.
  - Logic ops and PASS: C unchanged, V=0.
  - Z = result==0; N = result MSB.
- MUL (MUL_EN=1): EXEC to MULT; unsigned shift-add, one bit per cycle, exactly WIDTH cycles in MULT.
  - Writes low half to dest and high half to D.
  - If dest is D, the low half is written to D and the high half is discarded.
  - Writeback on the edge ending the last MULT cycle; total latency WIDTH+2 edges from accept.
  - C = (high half != 0), V=0, Z/N from the low half.
- MUL with MUL_EN=0: result 0, no register write, err set, flags unchanged.
- No-write destination (load_addr[7:4] != 4'h1): result, flags and done still update; no register written.
- ld_en: writes ld_sel on any edge, independent of FSM state. If it coincides with writeback to the same register, the ALU writeback wins. An operand latch on that same edge samples the pre-edge value.
- dbg_data: combinational, reflects the register value after the most recent edge.

Decomposition:
- Shared package alu_pkg holds:
  - opcode enum (OP_ADD..OP_PASSB)
  - register select constants (REG_A=0, REG_X=1, REG_Y=2, REG_D=3)
  - LOAD_PAGE=4'h1
  - flag bit indices
  - FSM state enum
- Sub-module alu_core: purely combinational opcode/operand/carry-in to result/flags. The FSM, register file and multiplier stay in alu_exec.

Test Plan:
- Reset check: after rst, dbg all registers = 0, in_ready=1, flags=0. ld X=0x7F, Y=0x01; ADD src_a=X src_b=Y dest A -> done 2 edges after accept, A=0x80, flags N=1 V=1 C=0 Z=0.
- Borrow and wrap: A=0x00, Y=0x01, SUB A,Y -> 0xFF, C=1 N=1. Then DEC on A=0x00 -> 0xFF, C=1. INC on A=0xFF -> 0x00, Z=1 C=1.
- MUL timing: X=0x0F, Y=0x11, MUL dest A -> A=0xFF, D=0x00, C=0. Again with X=0xFF, Y=0xFF -> A=0x01, D=0xFE, C=1. done exactly 10 edges after accept; in_ready=0 throughout; ce_n pulses during MULT ignored.
- Error and no-write cases: src_a=4'h5 -> operand 0, err=1 and stays set. load_addr=8'h20 -> result/flags/done update, no register changes.
- Load collision: ld_en to A coinciding with a writeback edge to A -> ALU value retained.
- Mid-operation reset: assert rst mid-MULT -> all outputs at reset values immediately; no done pulse; next instruction accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, register-select, flag-index and FSM definitions for the ALU execute stage.
// No logic; constants and types only.
// Imported by alu_core and alu_exec.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_ADC   = 4'h1,
    OP_SUB   = 4'h2,
    OP_SBB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_NOT   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_ROL   = 4'hA,
    OP_ROR   = 4'hB,
    OP_INC   = 4'hC,
    OP_DEC   = 4'hD,
    OP_MUL   = 4'hE,
    OP_PASSB = 4'hF
  } op_e;

  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_X = 2'd1;
  localparam logic [1:0] REG_Y = 2'd2;
  localparam logic [1:0] REG_D = 2'd3;

  // Upper nibble of load_addr that enables a register writeback
  localparam logic [3:0] LOAD_PAGE = 4'h1;

  // Bit positions inside the {N,V,C,Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULT = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: opcode + operands + incoming flags -> result and {N,V,C,Z}.
// Latency: zero (pure combinational).
// No flow control; MUL is not computed here (result 0, flags passed through).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_flags,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  logic             w_cin;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_c_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_keep;

  assign w_cin   = i_flags[FLAG_C];
  assign w_a_ext = {1'b0, i_a};
  assign w_b_ext = {1'b0, i_b};
  assign w_c_ext = {{WIDTH{1'b0}}, w_cin};

  // Opcode decode: the extra sum bit is carry for additions and borrow for subtractions
  always_comb begin
    w_sum  = '0;
    w_res  = '0;
    w_c    = w_cin;
    w_v    = 1'b0;
    w_keep = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_sum = w_a_ext + w_b_ext;
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_ADC: begin
        w_sum = w_a_ext + w_b_ext + w_c_ext;
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sum = w_a_ext - w_b_ext;
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SBB: begin
        w_sum = w_a_ext - w_b_ext - w_c_ext;
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND: w_res = i_a & i_b;
      OP_OR:  w_res = i_a | i_b;
      OP_XOR: w_res = i_a ^ i_b;
      OP_NOT: w_res = ~i_a;
      OP_SHL: begin
        w_res = {i_a[WIDTH-2:0], 1'b0};
        w_c   = i_a[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {1'b0, i_a[WIDTH-1:1]};
        w_c   = i_a[0];
      end
      OP_ROL: begin
        w_res = {i_a[WIDTH-2:0], w_cin};
        w_c   = i_a[WIDTH-1];
      end
      OP_ROR: begin
        w_res = {w_cin, i_a[WIDTH-1:1]};
        w_c   = i_a[0];
      end
      OP_INC: begin
        w_sum = w_a_ext + (WIDTH+1)'(1);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = ~i_a[WIDTH-1] & w_res[WIDTH-1];
      end
      OP_DEC: begin
        w_sum = w_a_ext - (WIDTH+1)'(1);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = i_a[WIDTH-1] & ~w_res[WIDTH-1];
      end
      OP_MUL:   w_keep = 1'b1;
      OP_PASSB: w_res  = i_b;
      default:  w_keep = 1'b1;
    endcase
  end

  assign o_result = w_res;
  assign o_flags  = w_keep ? i_flags : {w_res[WIDTH-1], w_v, w_c, (w_res == '0)};

endmodule

// File: rtl/alu_exec.sv
// Execute/writeback stage: owns A/X/Y/D and flags, runs one decoded instruction at a time.
// Latency: writeback on the edge after accept; MUL writes back WIDTH edges later than that.
// Backpressure: in_ready is high only in IDLE; ce_n is ignored while busy (decoder holds).
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_n,
  input  logic [3:0]       opcode,
  input  logic [3:0]       src_a,
  input  logic [3:0]       src_b,
  input  logic [7:0]       load_addr,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err,
  input  logic             ld_en,
  input  logic [1:0]       ld_sel,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_regs [4];
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [3:0]         r_op;
  logic [1:0]         r_dest;
  logic               r_wen;
  logic               r_err;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH-1:0]   w_opb;
  logic               w_src_bad;
  logic               w_op_bad;
  logic               w_is_mul;
  logic               w_mul_go;
  logic               w_mul_last;
  logic               w_wb_alu;
  logic               w_wb_mul;
  logic               w_alu_write;
  logic [WIDTH-1:0]   w_core_res;
  logic [3:0]         w_core_flags;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_hi_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [WIDTH-1:0]   w_mul_hi;
  logic               w_unused;

  // load_addr[3:2] carry no meaning for destination decode
  assign w_unused = ^load_addr[3:2];

  // Out-of-range selects read as zero
  assign w_opa     = (src_a[3:2] == 2'b00) ? r_regs[src_a[1:0]] : '0;
  assign w_opb     = (src_b[3:2] == 2'b00) ? r_regs[src_b[1:0]] : '0;
  assign w_src_bad = (src_a[3:2] != 2'b00) || (src_b[3:2] != 2'b00);
  assign w_op_bad  = (opcode == OP_MUL) && (MUL_EN == 1'b0);

  assign w_accept    = (r_state == ST_IDLE) && !ce_n;
  assign w_is_mul    = (r_op == OP_MUL);
  assign w_mul_go    = w_is_mul && (MUL_EN == 1'b1);
  assign w_mul_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_wb_alu    = (r_state == ST_EXEC) && !w_mul_go;
  assign w_wb_mul    = (r_state == ST_MULT) && w_mul_last;
  assign w_alu_write = w_wb_alu && r_wen && !w_is_mul;

  // Shift-add step: conditionally add multiplicand to the high half, then shift right
  assign w_addend   = r_prod[0] ? {1'b0, r_opa} : '0;
  assign w_hi_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + w_addend;
  assign w_prod_nxt = {w_hi_sum, r_prod[WIDTH-1:1]};
  assign w_mul_lo   = w_prod_nxt[WIDTH-1:0];
  assign w_mul_hi   = w_prod_nxt[2*WIDTH-1:WIDTH];

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (r_op),
    .i_a      (r_opa),
    .i_b      (r_opb),
    .i_flags  (r_flags),
    .o_result (w_core_res),
    .o_flags  (w_core_flags)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (!ce_n) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: w_state_nxt = w_mul_go ? ST_MULT : ST_IDLE;
      ST_MULT: if (w_mul_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture operands and instruction fields on accept; err is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa  <= '0;
      r_opb  <= '0;
      r_op   <= '0;
      r_dest <= '0;
      r_wen  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_opa  <= w_opa;
      r_opb  <= w_opb;
      r_op   <= opcode;
      r_dest <= load_addr[1:0];
      r_wen  <= (load_addr[7:4] == LOAD_PAGE);
      if (w_src_bad || w_op_bad) r_err <= 1'b1;
    end
  end

  // Iterative multiplier: seeded in EXEC, one product bit per MULT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod <= '0;
      r_cnt  <= '0;
    end else if (r_state == ST_EXEC) begin
      r_prod <= {{WIDTH{1'b0}}, r_opb};
      r_cnt  <= '0;
    end else if (r_state == ST_MULT) begin
      r_prod <= w_prod_nxt;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Register file; ALU writeback is ordered last so it wins over a same-edge external load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      if (ld_en) r_regs[ld_sel] <= ld_data;
      if (w_alu_write) r_regs[r_dest] <= w_core_res;
      if (w_wb_mul && r_wen) begin
        r_regs[r_dest] <= w_mul_lo;
        if (r_dest != REG_D) r_regs[REG_D] <= w_mul_hi;
      end
    end
  end

  // Result, flags and the one-cycle done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_done <= w_wb_alu || w_wb_mul;
      if (w_wb_alu) begin
        r_result <= w_core_res;
        r_flags  <= w_core_flags;
      end else if (w_wb_mul) begin
        r_result <= w_mul_lo;
        r_flags  <= {w_mul_lo[WIDTH-1], 1'b0, (w_mul_hi != '0), (w_mul_lo == '0)};
      end
    end
  end

  assign done     = r_done;
  assign result   = r_result;
  assign flags    = r_flags;
  assign err      = r_err;
  assign dbg_data = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus pushes expected writebacks, monitor checks on done.
module tb_alu_exec;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         ce_n;
  logic [3:0]   opcode;
  logic [3:0]   src_a;
  logic [3:0]   src_b;
  logic [7:0]   load_addr;
  logic         in_ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         err;
  logic         ld_en;
  logic [1:0]   ld_sel;
  logic [W-1:0] ld_data;
  logic [1:0]   dbg_sel;
  logic [W-1:0] dbg_data;

  alu_exec #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ce_n(ce_n), .opcode(opcode), .src_a(src_a), .src_b(src_b),
    .load_addr(load_addr), .in_ready(in_ready), .busy(busy), .done(done), .result(result),
    .flags(flags), .err(err), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int res;
    int flg;
    int cyc;
    int err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_unexp  = 0;

  // Reference architectural state
  int m_regs[4];
  int mN, mV, mC, mZ, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    mN = 0; mV = 0; mC = 0; mZ = 0; m_err = 0;
  endtask

  // Instruction semantics in plain integer arithmetic
  task automatic model_exec(input int op, input int sa, input int sb, input int la,
                            output int res, output int fl);
    int a, b, s, sv, p, hi, cin, dst;
    bit wr;
    a   = (sa < 4) ? m_regs[sa] : 0;
    b   = (sb < 4) ? m_regs[sb] : 0;
    if (sa > 3 || sb > 3) m_err = 1;
    wr  = ((la / 16) == 1);
    dst = la % 4;
    cin = mC;
    res = 0;
    case (op)
      0, 1, 12: begin
        s  = (op == 12) ? a + 1 : a + b + ((op == 1) ? cin : 0);
        sv = (op == 12) ? sgn(a) + 1 : sgn(a) + sgn(b) + ((op == 1) ? cin : 0);
        res = s & 255; mC = (s > 255); mV = (sv > 127 || sv < -128);
      end
      2, 3, 13: begin
        s  = (op == 13) ? a - 1 : a - b - ((op == 3) ? cin : 0);
        sv = (op == 13) ? sgn(a) - 1 : sgn(a) - sgn(b) - ((op == 3) ? cin : 0);
        res = s & 255; mC = (s < 0); mV = (sv > 127 || sv < -128);
      end
      4:  begin res = a & b;          mV = 0; end
      5:  begin res = a | b;          mV = 0; end
      6:  begin res = a ^ b;          mV = 0; end
      7:  begin res = 255 - a;        mV = 0; end
      8:  begin res = (a * 2) & 255;       mC = (a >= 128); mV = 0; end
      9:  begin res = a / 2;               mC = a % 2;      mV = 0; end
      10: begin res = (a * 2 + cin) & 255; mC = (a >= 128); mV = 0; end
      11: begin res = a / 2 + cin * 128;   mC = a % 2;      mV = 0; end
      15: begin res = b;              mV = 0; end
      default: begin
        p = a * b; res = p % 256; hi = p / 256;
        mC = (hi != 0); mV = 0;
      end
    endcase
    if (wr) begin
      if (op == 14 && dst != 3) m_regs[3] = hi;
      m_regs[dst] = res;
    end
    mN = (res >= 128);
    mZ = (res == 0);
    fl = mN * 8 + mV * 4 + mC * 2 + mZ;
  endtask

  task automatic issue(input int op, input int sa, input int sb, input int la);
    exp_t e;
    int   g, r, f;
    g = 0;
    while (in_ready !== 1'b1 && g < 64) begin @(negedge clk); g++; end
    chk("issue_in_ready", in_ready, 1);
    model_exec(op, sa, sb, la, r, f);
    e.res = r;
    e.flg = f;
    e.err = m_err;
    e.cyc = cyc + ((op == 14) ? W + 2 : 2);
    exp_q.push_back(e);
    opcode = 4'(op); src_a = 4'(sa); src_b = 4'(sb); load_addr = 8'(la);
    ce_n = 1'b0;
    @(negedge clk);
    ce_n = 1'b1;
  endtask

  task automatic load(input int sel, input int val);
    ld_en = 1'b1; ld_sel = 2'(sel); ld_data = 8'(val);
    @(negedge clk);
    ld_en = 1'b0;
    m_regs[sel] = val;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && g < 64) begin @(negedge clk); g++; end
    chk("idle_reached", exp_q.size(), 0);
  endtask

  task automatic rd(input int sel, output logic [W-1:0] v);
    dbg_sel = 2'(sel);
    #1;
    v = dbg_data;
    @(negedge clk);
  endtask

  task automatic check_regs(input string name);
    logic [W-1:0] v;
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      chk(name, v, m_regs[i]);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_err++; n_unexp++;
        $display("FAIL unexpected_done: got done=1, expected no pending instruction (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_result", result, mon_e.res);
        chk("wb_flags", flags, mon_e.flg);
        chk("wb_cycle", cyc, mon_e.cyc);
        chk("wb_err", err, mon_e.err);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] v;
    rst = 1'b1; ce_n = 1'b1; opcode = '0; src_a = '0; src_b = '0; load_addr = '0;
    ld_en = 1'b0; ld_sel = '0; ld_data = '0; dbg_sel = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    check_regs("rst_regs");

    // Signed overflow on ADD
    load(1, 8'h7F); load(2, 8'h01);
    issue(0, 1, 2, 8'h10);
    wait_idle();
    rd(0, v); chk("add_A", v, 8'h80);
    chk("add_flags", flags, 4'b1100);

    // Borrow / wrap
    load(0, 8'h00);
    issue(2, 0, 2, 8'h10); wait_idle();
    rd(0, v); chk("sub_A", v, 8'hFF); chk("sub_flags", flags, 4'b1010);
    load(0, 8'h00);
    issue(13, 0, 0, 8'h10); wait_idle();
    rd(0, v); chk("dec_A", v, 8'hFF); chk("dec_flags", flags, 4'b1010);
    issue(12, 0, 0, 8'h10); wait_idle();
    rd(0, v); chk("inc_A", v, 8'h00); chk("inc_flags", flags, 4'b0011);

    // MUL timing, stall and ignored strobes
    load(1, 8'h0F); load(2, 8'h11);
    issue(14, 1, 2, 8'h10);
    for (int i = 0; i < 9; i++) begin
      chk("mul_in_ready", in_ready, 0);
      chk("mul_busy", busy, 1);
      opcode = 4'h0;
      ce_n = (i % 2 == 1) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    ce_n = 1'b1;
    wait_idle();
    rd(0, v); chk("mul1_A", v, 8'hFF);
    rd(3, v); chk("mul1_D", v, 8'h00);
    load(1, 8'hFF); load(2, 8'hFF);
    issue(14, 1, 2, 8'h10); wait_idle();
    rd(0, v); chk("mul2_A", v, 8'h01);
    rd(3, v); chk("mul2_D", v, 8'hFE);
    chk("mul2_flags", flags, 4'b0010);
    check_regs("mul_regs");

    // Illegal select, then sticky err and a no-write destination
    load(2, 8'h2A);
    issue(0, 5, 2, 8'h11); wait_idle();
    rd(1, v); chk("illegal_src_X", v, 8'h2A);
    chk("err_set", err, 1);
    issue(6, 1, 2, 8'h20); wait_idle();
    chk("nowrite_result", result, 8'h00);
    chk("err_sticky", err, 1);
    check_regs("nowrite_regs");

    // External load colliding with writeback to the same register
    load(0, 8'h11); load(2, 8'h3C);
    issue(15, 0, 2, 8'h10);
    ld_en = 1'b1; ld_sel = 2'd0; ld_data = 8'h55;
    @(negedge clk);
    ld_en = 1'b0;
    wait_idle();
    rd(0, v); chk("collide_A", v, 8'h3C);

    // External load on the accept edge: operand sees the old value
    load(1, 8'h05); load(2, 8'h03);
    ld_en = 1'b1; ld_sel = 2'd1; ld_data = 8'h40;
    issue(0, 1, 2, 8'h10);
    ld_en = 1'b0;
    m_regs[1] = 8'h40;
    wait_idle();
    rd(0, v); chk("presample_A", v, 8'h08);
    rd(1, v); chk("presample_X", v, 8'h40);

    // Randomized instruction stream
    for (int k = 0; k < 80; k++) begin
      int op, sa, sb, la;
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        load($urandom_range(0, 3), $urandom_range(0, 255));
      end
      op = $urandom_range(0, 15);
      sa = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      sb = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      la = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255) : 16 + $urandom_range(0, 15);
      issue(op, sa, sb, la);
      if (k % 8 == 7) begin
        wait_idle();
        check_regs("rand_regs");
      end
    end
    wait_idle();
    check_regs("rand_final_regs");

    // Reset in the middle of a multiply
    load(1, 8'h0F); load(2, 8'h11);
    issue(14, 1, 2, 8'h10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    check_regs("midrst_regs");
    rst = 1'b0;
    repeat (14) @(negedge clk);
    chk("midrst_no_done", n_unexp, 0);
    load(1, 8'h21); load(2, 8'h12);
    issue(0, 1, 2, 8'h13);
    wait_idle();
    rd(3, v); chk("post_rst_D", v, 8'h33);
    check_regs("post_rst_regs");

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
